// File: rtl/led_pattern_arbiter_pkg.sv
// Shared LED/status definitions: FSM state encodings and default sizing
// constants used by the LED pattern arbiter and its step prescaler.
package led_pattern_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } led_state_t;

    localparam int LED_DEF_NUM_REQ   = 4;
    localparam int LED_DEF_PAT_W     = 32;
    localparam int LED_DEF_STEP_DIV  = 2097152;  // 2^21 CLK cycles per step
    localparam int LED_DEF_GAP_STEPS = 2;

endpackage

// File: rtl/led_pattern_arbiter_if.sv
// Requester-side bundle of the LED pattern arbiter.
//   req     : level request per requester
//   pattern : requester i pattern at [i*PAT_W +: PAT_W]
//   grant   : one-hot owner while its pattern plays
//   done    : 1-cycle pulse when a granted pattern completed fully
//   busy    : high while a pattern or the trailing off-gap is in progress
//   led     : registered LED drive (LED and its mirror pin)
// master = status sources / top level, slave = arbiter.
interface led_pattern_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int PAT_W   = 32
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*PAT_W-1:0] pattern;
    logic [NUM_REQ-1:0]       grant;
    logic                     done;
    logic                     busy;
    logic                     led;

    modport master (output req, pattern, input grant, done, busy, led);
    modport slave  (input req, pattern, output grant, done, busy, led);
endinterface

// File: rtl/led_step_prescaler.sv
// Step prescaler: counts 0..STEP_DIV-1 while enabled and flags the last
// count as a step tick. clr forces the count back to 0 on the next edge.
//   CLK, RST : clock, async active-high reset
//   en       : count enable
//   clr      : synchronous clear (wins over en)
//   tick     : high while enabled and the count is STEP_DIV-1
module led_step_prescaler
    import led_pattern_arbiter_pkg::*;
#(
    parameter int STEP_DIV = LED_DEF_STEP_DIV
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int             CNT_W    = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == CNT_LAST);
endmodule

// File: rtl/led_pattern_arbiter.sv
// Shares one user LED among NUM_REQ requesters. A round-robin pick grants a
// requester, latches its pattern and plays it LSB-first, one bit per step
// tick, then holds the LED off for GAP_STEPS steps before re-arbitrating.
//   CLK, RST : clock, async active-high reset
//   bus      : requester bundle (req/pattern in, grant/done/busy/led out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no owner; arbitrate among asserted requests
//   ST_PLAY | owner's latched pattern is shifting out on led
//   ST_GAP  | led held off for GAP_STEPS steps after a pattern or abort
module led_pattern_arbiter
    import led_pattern_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = LED_DEF_NUM_REQ,
    parameter int PAT_W     = LED_DEF_PAT_W,
    parameter int STEP_DIV  = LED_DEF_STEP_DIV,
    parameter int GAP_STEPS = LED_DEF_GAP_STEPS
) (
    input  logic                CLK,
    input  logic                RST,
    led_pattern_arbiter_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int STEP_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W  = (GAP_STEPS > 1) ? $clog2(GAP_STEPS) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_STEPS > 0) ? GAP_STEPS - 1 : 0);

    led_state_t         state_q, state_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic               led_q, led_n, done_q, done_n, busy_q, busy_n;
    logic [IDX_W-1:0]   rr_q, rr_n, owner_q, owner_n;
    logic [STEP_W-1:0]  step_q, step_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic [PAT_W-1:0]   pat_q, pat_n;
    logic [IDX_W-1:0]   pick;
    logic [PAT_W-1:0]   pick_pat;
    logic [STEP_W-1:0]  step_inc;
    logic               tick, leave;

    // First asserted request at or above ptr, wrapping modulo NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                  input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && r[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_LAST) ? '0 : i + 1'b1;
    endfunction

    assign pick     = rr_pick(bus.req, rr_q);
    assign pick_pat = bus.pattern[pick*PAT_W +: PAT_W];
    assign step_inc = step_q + 1'b1;

    // Cleared on every state change so each state starts a full step.
    led_step_prescaler #(.STEP_DIV(STEP_DIV)) u_presc (
        .CLK  (CLK),
        .RST  (RST),
        .en   (state_q != ST_IDLE),
        .clr  (state_n != state_q),
        .tick (tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rr_q    <= '0;
            owner_q <= '0;
            step_q  <= '0;
            gap_q   <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            led_q   <= led_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
            rr_q    <= rr_n;
            owner_q <= owner_n;
            step_q  <= step_n;
            gap_q   <= gap_n;
            pat_q   <= pat_n;
        end
    end

    // led is loaded with the bit for the step being entered, so it changes on
    // the same edge as step and every bit is held a full STEP_DIV cycles.
    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        led_n   = led_q;
        done_n  = 1'b0;
        busy_n  = busy_q;
        rr_n    = rr_q;
        owner_n = owner_q;
        step_n  = step_q;
        gap_n   = gap_q;
        pat_n   = pat_q;
        leave   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    owner_n       = pick;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    pat_n         = pick_pat;
                    step_n        = '0;
                    led_n         = pick_pat[0];
                    busy_n        = 1'b1;
                    state_n       = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A dropped request aborts even on the final tick: no done.
                if (!bus.req[owner_q]) begin
                    leave = 1'b1;
                end else if (tick) begin
                    if (step_q == STEP_LAST) begin
                        leave  = 1'b1;
                        done_n = 1'b1;
                    end else begin
                        step_n = step_inc;
                        led_n  = pat_q[step_inc];
                    end
                end
                if (leave) begin
                    grant_n = '0;
                    led_n   = 1'b0;
                    step_n  = '0;
                    gap_n   = '0;
                    rr_n    = next_idx(owner_q);
                    if (GAP_STEPS == 0) begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                led_n = 1'b0;
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        gap_n   = '0;
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                    end else begin
                        gap_n = gap_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
                led_n   = 1'b0;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.led   = led_q;
endmodule
